// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Purpose:
//   Instruction-fetch stage. Owns the program counter and the IF/ID pipeline
//   register. Every cycle it either issues the sequential fetch (PC+4) or the
//   redirect target supplied by the jump unit in EX. The instruction memory
//   is synchronous with one cycle of latency. A one-entry skid buffer absorbs
//   hazard stalls, so releasing a stall costs no bubble. A redirect flushes
//   every younger fetch.
//
// Ports:
//   clk        in   1      single clock, rising edge
//   reset      in   1      synchronous, active-high
//   PcSel      in   1      redirect request from the jump unit
//   BrPC       in   32     redirect target, only [PC_W-1:0] is used
//   Stall      in   1      hazard hold for PC and IF/ID
//   imem_req   out  1      fetch issued this cycle
//   imem_addr  out  PC_W   address fetched this cycle
//   imem_rdata in   32     instruction for the previous cycle's request
//   if_pc      out  PC_W   IF/ID program counter
//   if_instr   out  32     IF/ID instruction
//   if_valid   out  1      IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int              PC_W      = 9,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            Stall,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            if_valid
);

    // Fetch state: RUN while the skid buffer is empty, HOLD while it is full.
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]      state;
    logic [PC_W-1:0] pc;
    logic            inflight;
    logic [PC_W-1:0] inflight_pc;
    logic [PC_W-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic            skid_valid;

    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] pc_next_seq;
    logic [PC_W-1:0] tgt_next_seq;

    assign skid_valid = (state == ST_HOLD);

    // Redirect targets are word aligned; the low two bits are dropped.
    assign tgt          = {BrPC[PC_W-1:2], 2'b00};
    // Sequential arithmetic wraps silently at 2^PC_W.
    assign pc_next_seq  = pc + PC_W'(4);
    assign tgt_next_seq = tgt + PC_W'(4);

    // Upper target bits and the forced-zero alignment bits are not used.
    logic unused_brpc;
    assign unused_brpc = &{1'b0, BrPC[31:PC_W], BrPC[1:0]};

    // Memory request side is combinational so the fetch address leaves in the
    // same cycle the decision is made.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        if (reset) begin
            imem_req  = 1'b0;
            imem_addr = RESET_PC;
        end else if (PcSel) begin
            imem_req  = 1'b1;
            imem_addr = tgt;
        end else if (!Stall) begin
            imem_req  = 1'b1;
            imem_addr = pc;
        end
    end

    // Control state and IF/ID register. Priority: reset > redirect > stall.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register, independent of
    // statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            inflight <= 1'b0;
            state    <= ST_RUN;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= NOP_INSTR;
        end else if (PcSel) begin
            // The response arriving now belongs to a wrong-path fetch and is
            // dropped along with the skid entry and the IF/ID contents.
            pc       <= tgt_next_seq;
            inflight <= 1'b1;
            state    <= ST_RUN;
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
        end else if (Stall) begin
            // No request goes out while stalled, so only the first stall
            // cycle can have a response to park; the skid never overflows.
            inflight <= 1'b0;
            if (inflight && !skid_valid) begin
                state <= ST_HOLD;
            end
        end else begin
            pc       <= pc_next_seq;
            inflight <= 1'b1;
            state    <= ST_RUN;
            if (skid_valid) begin
                // Release from a stall: the parked instruction goes first; the
                // request issued now fills IF/ID on the following cycle.
                if_valid <= 1'b1;
                if_pc    <= skid_pc;
                if_instr <= skid_instr;
            end else if (inflight) begin
                if_valid <= 1'b1;
                if_pc    <= inflight_pc;
                if_instr <= imem_rdata;
            end else begin
                if_valid <= 1'b0;
                if_pc    <= '0;
                if_instr <= NOP_INSTR;
            end
        end
    end

    // Datapath registers whose contents are qualified by inflight/state.
    // NOTE: these carry no reset; their value is never observed until the
    // matching valid flag has been set, so a reset term would only add logic.
    always_ff @(posedge clk) begin
        if (!reset && !PcSel) begin
            if (!Stall) begin
                inflight_pc <= pc;
            end else if (inflight && !skid_valid) begin
                skid_pc    <= inflight_pc;
                skid_instr <= imem_rdata;
            end
        end else if (!reset && PcSel) begin
            inflight_pc <= tgt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Purpose:
//   Directed testbench for fetch_stage. A one-cycle-latency memory model
//   returns a recognisable word per address; each cycle the bench applies
//   inputs and compares the fetch request and the IF/ID register against
//   hand-computed values.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int          PC_W = 9;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            reset;
    logic            PcSel;
    logic [31:0]     BrPC;
    logic            Stall;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic [PC_W-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            if_valid;

    int total = 0;
    int bad   = 0;

    fetch_stage #(
        .PC_W      (PC_W),
        .RESET_PC  ('0),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PcSel      (PcSel),
        .BrPC       (BrPC),
        .Stall      (Stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .if_valid   (if_valid)
    );

    always #5 clk = ~clk;

    // Each address returns a distinct word; idle cycles return garbage so a
    // stale consumption shows up.
    function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs mid-cycle, advance.
    // if_pc is compared only when the slot is valid.
    task automatic cyc(input int n, input logic rst, input logic ps,
                       input logic [31:0] br, input logic st,
                       input logic e_req, input logic [PC_W-1:0] e_addr,
                       input logic e_valid, input logic [PC_W-1:0] e_pc);
        reset = rst;
        PcSel = ps;
        BrPC  = br;
        Stall = st;
        #2;
        check($sformatf("c%0d req", n), 32'(imem_req), 32'(e_req));
        if (e_req || rst)
            check($sformatf("c%0d addr", n), 32'(imem_addr), 32'(e_addr));
        check($sformatf("c%0d valid", n), 32'(if_valid), 32'(e_valid));
        if (e_valid) begin
            check($sformatf("c%0d pc", n), 32'(if_pc), 32'(e_pc));
            check($sformatf("c%0d instr", n), if_instr, mem_word(e_pc));
        end else begin
            check($sformatf("c%0d instr", n), if_instr, NOP);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        PcSel = 1'b0;
        BrPC  = '0;
        Stall = 1'b0;
        @(posedge clk);
        #1;
        // Reset cycle: no request, address at RESET_PC, IF/ID cleared.
        cyc(99, 1, 0, 0, 0, 0, 9'h000, 0, 0);
        check("rst if_pc", 32'(if_pc), 0);

        // Free run from RESET_PC; first valid instruction in cycle 2.
        cyc(0, 0, 0, 0, 0, 1, 9'h000, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 9'h004, 0, 0);
        cyc(2, 0, 0, 0, 0, 1, 9'h008, 1, 9'h000);
        cyc(3, 0, 0, 0, 0, 1, 9'h00C, 1, 9'h004);
        // Three-cycle stall while if_pc=8.
        cyc(4, 0, 0, 0, 1, 0, 9'h010, 1, 9'h008);
        cyc(5, 0, 0, 0, 1, 0, 9'h010, 1, 9'h008);
        cyc(6, 0, 0, 0, 1, 0, 9'h010, 1, 9'h008);
        // Release: stream continues 12,16 with no gap or repeat.
        cyc(7, 0, 0, 0, 0, 1, 9'h010, 1, 9'h008);
        cyc(8, 0, 0, 0, 0, 1, 9'h014, 1, 9'h00C);
        // Redirect to 0x40 while the stream is at 0x10.
        cyc(9, 0, 1, 32'h40, 0, 1, 9'h040, 1, 9'h010);
        cyc(10, 0, 0, 0, 0, 1, 9'h044, 0, 0);
        cyc(11, 0, 0, 0, 0, 1, 9'h048, 1, 9'h040);
        cyc(12, 0, 0, 0, 0, 1, 9'h04C, 1, 9'h044);
        // Fill the skid, then redirect together with Stall.
        cyc(13, 0, 0, 0, 1, 0, 9'h050, 1, 9'h048);
        cyc(14, 0, 0, 0, 1, 0, 9'h050, 1, 9'h048);
        cyc(15, 0, 1, 32'h80, 1, 1, 9'h080, 1, 9'h048);
        cyc(16, 0, 0, 0, 0, 1, 9'h084, 0, 0);
        cyc(17, 0, 0, 0, 0, 1, 9'h088, 1, 9'h080);
        cyc(18, 0, 0, 0, 0, 1, 9'h08C, 1, 9'h084);
        // Unaligned redirect near the top, then wrap past 0x1FC.
        cyc(19, 0, 1, 32'h1F7, 0, 1, 9'h1F4, 1, 9'h088);
        cyc(20, 0, 0, 0, 0, 1, 9'h1F8, 0, 0);
        cyc(21, 0, 0, 0, 0, 1, 9'h1FC, 1, 9'h1F4);
        cyc(22, 0, 0, 0, 0, 1, 9'h000, 1, 9'h1F8);
        cyc(23, 0, 0, 0, 0, 1, 9'h004, 1, 9'h1FC);
        cyc(24, 0, 0, 0, 0, 1, 9'h008, 1, 9'h000);
        // BrPC=0x123 fetches 0x120.
        cyc(25, 0, 1, 32'h0000_0123, 0, 1, 9'h120, 1, 9'h004);
        cyc(26, 0, 0, 0, 0, 1, 9'h124, 0, 0);
        cyc(27, 0, 0, 0, 0, 1, 9'h128, 1, 9'h120);
        // Reset in the middle of a stall with the skid full.
        cyc(28, 0, 0, 0, 1, 0, 9'h12C, 1, 9'h124);
        cyc(29, 0, 0, 0, 1, 0, 9'h12C, 1, 9'h124);
        cyc(30, 1, 0, 0, 1, 0, 9'h000, 1, 9'h124);
        cyc(31, 0, 0, 0, 0, 1, 9'h000, 0, 0);
        cyc(32, 0, 0, 0, 0, 1, 9'h004, 0, 0);
        cyc(33, 0, 0, 0, 0, 1, 9'h008, 1, 9'h000);
        cyc(34, 0, 0, 0, 0, 1, 9'h00C, 1, 9'h004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
